// File: rtl/pretu_pkg.sv
// Shared definitions for the PreTu tile sequencer.
//   - DW_DEFAULT : default input pixel width (outputs are DW+2 bits)
//   - TILE_DIM   : tile edge length (4x4 Winograd F(2,3) input tile)
//   - state_t    : sequencer job state
//   - row/tile typedefs for the default pixel width
//   - LANE_*     : positions of a, b, c, d inside a row or column
package pretu_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int TILE_DIM   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef logic [TILE_DIM-1:0][DW_DEFAULT-1:0]                 in_row_t;
    typedef logic [TILE_DIM-1:0][TILE_DIM-1:0][DW_DEFAULT-1:0]   in_tile_t;
    typedef logic [TILE_DIM-1:0][TILE_DIM-1:0][DW_DEFAULT+1:0]   out_tile_t;

    localparam int LANE_A = 0;
    localparam int LANE_B = 1;
    localparam int LANE_C = 2;
    localparam int LANE_D = 3;

endpackage

// File: rtl/pretu_tile_sequencer_pretu.sv
// PreTu: combinational 4x4 Winograd input transform Y = B^T X B.
//   x : 16 signed DW-bit pixels, X00 at the LSBs, row-major
//   y : 16 signed (DW+2)-bit results, Y00 at the LSBs, row-major
// The column pass (B^T X) produces DW+1-bit intermediates, the row pass
// produces DW+2-bit results; both are exact, with no saturation.
module pretu
    import pretu_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [TILE_DIM*TILE_DIM*DW-1:0]     x,
    output logic [TILE_DIM*TILE_DIM*(DW+2)-1:0] y
);

    localparam int YW = DW + 2;

    logic [DW:0]   xs [TILE_DIM][TILE_DIM];
    logic [DW:0]   t  [TILE_DIM][TILE_DIM];
    logic [YW-1:0] ts [TILE_DIM][TILE_DIM];

    genvar gi, gj;
    generate
        for (gi = 0; gi < TILE_DIM; gi++) begin : g_row
            for (gj = 0; gj < TILE_DIM; gj++) begin : g_col
                // Sign-extend one bit before each stage so add/sub is exact.
                assign xs[gi][gj] = {x[(gi*TILE_DIM+gj)*DW+DW-1], x[(gi*TILE_DIM+gj)*DW +: DW]};
                assign ts[gi][gj] = {t[gi][gj][DW], t[gi][gj]};
            end
        end

        for (gi = 0; gi < TILE_DIM; gi++) begin : g_pass
            // Column pass on column gi: T = B^T X.
            assign t[0][gi] = xs[LANE_A][gi] - xs[LANE_C][gi];
            assign t[1][gi] = xs[LANE_B][gi] + xs[LANE_C][gi];
            assign t[2][gi] = xs[LANE_C][gi] - xs[LANE_B][gi];
            assign t[3][gi] = xs[LANE_B][gi] - xs[LANE_D][gi];

            // Row pass on row gi: Y = T B.
            assign y[(gi*TILE_DIM+0)*YW +: YW] = ts[gi][LANE_A] - ts[gi][LANE_C];
            assign y[(gi*TILE_DIM+1)*YW +: YW] = ts[gi][LANE_B] + ts[gi][LANE_C];
            assign y[(gi*TILE_DIM+2)*YW +: YW] = ts[gi][LANE_C] - ts[gi][LANE_B];
            assign y[(gi*TILE_DIM+3)*YW +: YW] = ts[gi][LANE_B] - ts[gi][LANE_D];
        end
    endgenerate

endmodule

// File: rtl/pretu_tile_sequencer.sv
// PreTu tile sequencer: collects 4 input rows into a 4x4 tile, runs it
// through one PreTu instance, and presents the registered result on a
// valid/ready port, for a software-programmed number of tiles per job.
//   clk, rst_n           : clock, synchronous active-low reset
//   start, num_tiles     : job start pulse and tile count (IDLE only)
//   busy, done           : job active / one-cycle completion pulse
//   in_valid/in_ready    : input row handshake, in_row = X[r][3..0]
//   out_valid/out_ready  : output tile handshake
//   out_tile, out_idx    : transformed tile (Y00 at LSBs) and its index
module pretu_tile_sequencer
    import pretu_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [CNT_W-1:0]                    num_tiles,
    output logic                                busy,
    output logic                                done,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [TILE_DIM*DW-1:0]              in_row,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [TILE_DIM*TILE_DIM*(DW+2)-1:0] out_tile,
    output logic [CNT_W-1:0]                    out_idx
);

    state_t state_reg, state_next;

    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] load_cnt_reg;
    logic [CNT_W-1:0] emit_cnt_reg;
    logic [1:0]       row_cnt_reg;
    logic             tile_full_reg;
    logic             out_valid_reg;
    logic [TILE_DIM*TILE_DIM*(DW+2)-1:0] out_tile_reg;
    logic [CNT_W-1:0] out_idx_reg;

    logic [TILE_DIM*DW-1:0]              tile_buf_reg [TILE_DIM];
    logic [TILE_DIM*TILE_DIM*DW-1:0]     tile_flat;
    logic [TILE_DIM*TILE_DIM*(DW+2)-1:0] pretu_y;

    logic start_job;
    logic in_fire;
    logic out_fire;
    logic xfer;
    logic last_emit;

    genvar gi;
    generate
        for (gi = 0; gi < TILE_DIM; gi++) begin : g_flat
            assign tile_flat[gi*TILE_DIM*DW +: TILE_DIM*DW] = tile_buf_reg[gi];
        end
    endgenerate

    pretu #(.DW(DW)) u_pretu (
        .x (tile_flat),
        .y (pretu_y)
    );

    assign in_ready  = (state_reg == RUN) && !tile_full_reg && (load_cnt_reg < n_reg);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_reg && out_ready;
    // The output register is free when empty or being drained this cycle.
    assign xfer      = tile_full_reg && (!out_valid_reg || out_ready);
    assign last_emit = (emit_cnt_reg + CNT_W'(1)) == n_reg;

    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == FIN);
    assign out_valid = out_valid_reg;
    assign out_tile  = out_tile_reg;
    assign out_idx   = out_idx_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start_job  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    start_job  = 1'b1;
                    state_next = (num_tiles == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (out_fire && last_emit) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_reg         <= '0;
            load_cnt_reg  <= '0;
            emit_cnt_reg  <= '0;
            row_cnt_reg   <= '0;
            tile_full_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_tile_reg  <= '0;
            out_idx_reg   <= '0;
            for (int i = 0; i < TILE_DIM; i++) begin
                tile_buf_reg[i] <= '0;
            end
        end else if (start_job) begin
            n_reg         <= num_tiles;
            load_cnt_reg  <= '0;
            emit_cnt_reg  <= '0;
            row_cnt_reg   <= '0;
            tile_full_reg <= 1'b0;
        end else begin
            // in_fire needs !tile_full and xfer needs tile_full, so the two
            // tile_full updates below never collide.
            if (in_fire) begin
                tile_buf_reg[row_cnt_reg] <= in_row;
                row_cnt_reg               <= row_cnt_reg + 2'd1;
                if (row_cnt_reg == 2'd3) begin
                    tile_full_reg <= 1'b1;
                    load_cnt_reg  <= load_cnt_reg + CNT_W'(1);
                end
            end

            if (xfer) begin
                tile_full_reg <= 1'b0;
                out_valid_reg <= 1'b1;
                out_tile_reg  <= pretu_y;
                // When the held tile leaves in the same cycle, the new tile
                // takes the next index, i.e. the post-handshake emit count.
                out_idx_reg   <= out_fire ? (emit_cnt_reg + CNT_W'(1)) : emit_cnt_reg;
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end

            if (out_fire) begin
                emit_cnt_reg <= emit_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pretu_tile_sequencer.sv
module tb_pretu_tile_sequencer;

    localparam int DW    = 16;
    localparam int CNT_W = 16;
    localparam int YW    = DW + 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [CNT_W-1:0]    num_tiles = '0;
    logic                busy;
    logic                done;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [4*DW-1:0]     in_row = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [16*YW-1:0]    out_tile;
    logic [CNT_W-1:0]    out_idx;

    int checks = 0;
    int passes = 0;
    int bt [4][4];

    pretu_tile_sequencer #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_tiles (num_tiles),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tile  (out_tile),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    // Golden model: plain matrix products with the B^T constant matrix.
    function automatic logic [16*YW-1:0] golden(input logic [16*DW-1:0] tile);
        int x [4][4];
        int t [4][4];
        int yv;
        logic [16*YW-1:0] res;
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                x[r][c] = int'($signed(tile[(r*4+c)*DW +: DW]));
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                t[i][j] = 0;
                for (int k = 0; k < 4; k++) t[i][j] += bt[i][k] * x[k][j];
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                yv = 0;
                for (int k = 0; k < 4; k++) yv += t[i][k] * bt[j][k];
                res[(i*4+j)*YW +: YW] = YW'(yv);
            end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [CNT_W-1:0] n);
        start = 1'b1;
        num_tiles = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_row(input logic [4*DW-1:0] row);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_row = row;
        while (in_ready !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            checks++;
            $display("FAIL send_row_timeout in_ready=%b want 1", in_ready);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_tile(input logic [16*DW-1:0] tile);
        for (int r = 0; r < 4; r++) send_row(tile[r*4*DW +: 4*DW]);
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        while (out_valid !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            checks++;
            $display("FAIL out_valid_timeout out_valid=%b want 1", out_valid);
        end
    endtask

    function automatic logic [16*DW-1:0] rand_tile();
        logic [16*DW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_tile !== '0) $display("FAIL reset_out_tile got %h want 0", out_tile); else passes++;
        checks++; if (out_idx !== '0) $display("FAIL reset_out_idx got %0d want 0", out_idx); else passes++;
    endtask

    task automatic test_known_tile();
        logic [16*DW-1:0] tile;
        logic [16*YW-1:0] expv;
        // Rows [1 2 3 4] [5 6 7 8] [9 10 11 12] [13 14 15 16]
        tile = {16'd16, 16'd15, 16'd14, 16'd13, 16'd12, 16'd11, 16'd10, 16'd9,
                16'd8,  16'd7,  16'd6,  16'd5,  16'd4,  16'd3,  16'd2,  16'd1};
        // B^T X rows: [-8..] [14 16 18 20] [4..] [-8..]; then row op each.
        expv = '0;
        expv[1*YW +: YW]  = YW'(-16);
        expv[4*YW +: YW]  = YW'(-4);
        expv[5*YW +: YW]  = YW'(34);
        expv[6*YW +: YW]  = YW'(2);
        expv[7*YW +: YW]  = YW'(-4);
        expv[9*YW +: YW]  = YW'(8);
        expv[13*YW +: YW] = YW'(-16);
        out_ready = 1'b1;
        start_job(16'd1);
        checks++; if (busy !== 1'b1) $display("FAIL known_busy got %b want 1", busy); else passes++;
        for (int r = 0; r < 4; r++) send_row(tile[r*4*DW +: 4*DW]);
        checks++; if (out_valid !== 1'b0) $display("FAIL known_latency1 out_valid got %b want 0", out_valid); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL known_in_ready_full got %b want 0", in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1) $display("FAIL known_latency2 out_valid got %b want 1", out_valid); else passes++;
        checks++; if (out_tile !== expv) $display("FAIL known_tile got %h want %h", out_tile, expv); else passes++;
        checks++; if (out_idx !== 16'd0) $display("FAIL known_idx got %0d want 0", out_idx); else passes++;
        $display("known tile idx=%0d", out_idx);
        tick();
        checks++; if (done !== 1'b1) $display("FAIL known_done got %b want 1", done); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL known_busy_drop got %b want 0", busy); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL known_out_valid_clear got %b want 0", out_valid); else passes++;
        tick();
        checks++; if (done !== 1'b0) $display("FAIL known_done_once got %b want 0", done); else passes++;
    endtask

    task automatic test_extremes();
        logic [16*YW-1:0] expv;
        out_ready = 1'b1;
        // All +32767: only Y11 = 4*32767 survives.
        expv = '0;
        expv[5*YW +: YW] = YW'(131068);
        start_job(16'd1);
        send_tile({16{16'h7fff}});
        wait_out_valid();
        checks++; if (out_tile !== expv) $display("FAIL max_tile got %h want %h", out_tile, expv); else passes++;
        $display("max tile idx=%0d", out_idx);
        tick();
        tick();
        // All -32768: Y11 = -131072, the most negative 18-bit value.
        expv = '0;
        expv[5*YW +: YW] = YW'(-131072);
        start_job(16'd1);
        send_tile({16{16'h8000}});
        wait_out_valid();
        checks++; if (out_tile[5*YW +: YW] !== 18'h20000) $display("FAIL min_y11 got %h want 20000", out_tile[5*YW +: YW]); else passes++;
        checks++; if (out_tile !== expv) $display("FAIL min_tile got %h want %h", out_tile, expv); else passes++;
        $display("min tile idx=%0d", out_idx);
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [16*DW-1:0] tiles [3];
        for (int k = 0; k < 3; k++) tiles[k] = rand_tile();
        out_ready = 1'b0;
        start_job(16'd3);
        send_tile(tiles[0]);
        send_tile(tiles[1]);
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready c=%0d got %b want 0", c, in_ready); else passes++;
            checks++; if (out_valid !== 1'b1) $display("FAIL hold_out_valid c=%0d got %b want 1", c, out_valid); else passes++;
            checks++; if (out_idx !== 16'd0) $display("FAIL hold_idx c=%0d got %0d want 0", c, out_idx); else passes++;
            checks++; if (out_tile !== golden(tiles[0])) $display("FAIL hold_tile c=%0d got %h want %h", c, out_tile, golden(tiles[0])); else passes++;
        end
        out_ready = 1'b1;
        fork
            send_tile(tiles[2]);
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_out_valid();
                    checks++; if (out_idx !== CNT_W'(k)) $display("FAIL b2b_idx k=%0d got %0d want %0d", k, out_idx, k); else passes++;
                    checks++; if (out_tile !== golden(tiles[k])) $display("FAIL b2b_tile k=%0d got %h want %h", k, out_tile, golden(tiles[k])); else passes++;
                    $display("b2b tile idx=%0d", out_idx);
                    tick();
                end
                checks++; if (done !== 1'b1) $display("FAIL b2b_done got %b want 1", done); else passes++;
            end
        join
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL b2b_busy got %b want 0", busy); else passes++;
    endtask

    task automatic test_zero_tiles();
        in_valid = 1'b1;
        start_job(16'd0);
        checks++; if (done !== 1'b1) $display("FAIL zero_done got %b want 1", done); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL zero_busy got %b want 0", busy); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL zero_in_ready0 got %b want 0", in_ready); else passes++;
        tick();
        checks++; if (done !== 1'b0) $display("FAIL zero_done_once got %b want 0", done); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL zero_in_ready1 got %b want 0", in_ready); else passes++;
        tick();
        checks++; if (in_ready !== 1'b0) $display("FAIL zero_in_ready2 got %b want 0", in_ready); else passes++;
        in_valid = 1'b0;
        $display("zero-tile job complete");
    endtask

    task automatic test_midjob_reset();
        logic [16*DW-1:0] junk;
        logic [16*DW-1:0] fresh;
        junk  = rand_tile();
        fresh = rand_tile();
        out_ready = 1'b1;
        start_job(16'd1);
        send_row(junk[0 +: 4*DW]);
        send_row(junk[4*DW +: 4*DW]);
        rst_n = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_tile !== '0) $display("FAIL rst_out_tile got %h want 0", out_tile); else passes++;
        rst_n = 1'b1;
        start_job(16'd1);
        send_tile(fresh);
        wait_out_valid();
        checks++; if (out_tile !== golden(fresh)) $display("FAIL rst_fresh_tile got %h want %h", out_tile, golden(fresh)); else passes++;
        checks++; if (out_idx !== 16'd0) $display("FAIL rst_fresh_idx got %0d want 0", out_idx); else passes++;
        $display("post-reset tile idx=%0d", out_idx);
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [16*DW-1:0] tiles [10];
        int got;
        int t;
        for (int k = 0; k < 10; k++) tiles[k] = rand_tile();
        got = 0;
        t = 0;
        start_job(16'd10);
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    if (k == 3) begin
                        start = 1'b1;
                        num_tiles = 16'd5;
                        tick();
                        start = 1'b0;
                    end
                    for (int r = 0; r < 4; r++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        send_row(tiles[k][r*4*DW +: 4*DW]);
                    end
                end
            end
            begin
                while (got < 10 && t < 3000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid === 1'b1 && out_ready === 1'b1) begin
                        checks++; if (out_idx !== CNT_W'(got)) $display("FAIL rand_idx n=%0d got %0d want %0d", got, out_idx, got); else passes++;
                        checks++; if (out_tile !== golden(tiles[got])) $display("FAIL rand_tile n=%0d got %h want %h", got, out_tile, golden(tiles[got])); else passes++;
                        $display("random tile idx=%0d", out_idx);
                        got++;
                    end
                    tick();
                    t++;
                end
                if (got < 10) begin
                    checks++;
                    $display("FAIL rand_timeout tiles got %0d want 10", got);
                end
                checks++; if (done !== 1'b1) $display("FAIL rand_done got %b want 1", done); else passes++;
                checks++; if (out_valid !== 1'b0) $display("FAIL rand_extra_tile out_valid got %b want 0", out_valid); else passes++;
            end
        join
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL rand_busy got %b want 0", busy); else passes++;
    endtask

    initial begin
        bt = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
        test_reset();
        test_known_tile();
        test_extremes();
        test_back_to_back();
        test_zero_tiles();
        test_midjob_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
